// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MDU op encoding driven by the control unit, the FSM state type
// and the default busy-cycle counts for multiply and divide.
package mdu_pkg;

  typedef enum logic [3:0] {
    MduNone  = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMthi  = 4'd5,
    MduMtlo  = 4'd6,
    MduMfhi  = 4'd7,
    MduMflo  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned DefaultMultCycles = 5;
  localparam int unsigned DefaultDivCycles  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the E stage.
// A mult/div launch computes the full result immediately into shadow registers,
// then holds busy for a fixed number of cycles before committing to HI/LO.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          E stage holds a valid MDU op this cycle
//   mdu_op         operation (mdu_op_e)
//   src_a, src_b   forwarded rs / rt operands
//   busy           registered; mult/div in flight
//   mdu_out        HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo         architectural HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefaultMultCycles,
  parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  mdu_op_e     mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Dividing by 1 in place of 0 keeps the datapath X-free (the result is
  // discarded anyway); dividing by 1 in the -2^31 / -1 case yields exactly
  // the required quotient 0x80000000 and remainder 0 without overflow.
  assign div_zero = (src_b == 32'd0);
  assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign div_b    = (div_zero || div_ovf) ? 32'd1 : src_b;

  assign quot_s = $signed(src_a) / $signed(div_b);
  assign rem_s  = $signed(src_a) % $signed(div_b);
  assign quot_u = src_a / div_b;
  assign rem_u  = src_a % div_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (mdu_op)
            MduMult: begin
              {sh_hi_d, sh_lo_d} = prod_s;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            MduMultu: begin
              {sh_hi_d, sh_lo_d} = prod_u;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            MduDiv, MduDivu: begin
              // Divide by zero commits the current HI/LO back unchanged.
              if (div_zero) begin
                sh_hi_d = hi_q;
                sh_lo_d = lo_q;
              end else if (mdu_op == MduDiv) begin
                sh_hi_d = rem_s;
                sh_lo_d = quot_s;
              end else begin
                sh_hi_d = rem_u;
                sh_lo_d = quot_u;
              end
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            MduMthi: hi_d = src_a;
            MduMtlo: lo_d = src_a;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Any start while running is ignored.
        if (cnt_q <= CntW'(1)) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  always_comb begin
    mdu_out = 32'd0;
    case (mdu_op)
      MduMfhi: mdu_out = hi_q;
      MduMflo: mdu_out = lo_q;
      default: ;
    endcase
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops,
// checked against a behavioural HI/LO model and a scoreboard of pending results.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  mdu_op_e     mdu_op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] mdu_out, hi, lo;

  mult_div_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .mdu_out(mdu_out),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference state
  logic [31:0] m_hi = '0, m_lo = '0, pend_h = '0, pend_l = '0;
  int          ref_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [63:0] calc(input mdu_op_e op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] ch,
                                       input logic [31:0] cl);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub, uq, ur;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      MduMult:  return sa * sbv;
      MduMultu: return ua * ub;
      MduDiv: begin
        if (b == 32'd0) return {ch, cl};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      MduDivu: begin
        if (b == 32'd0) return {ch, cl};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {ch, cl};
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic step(input mdu_op_e op, input logic st, input logic [31:0] a,
                      input logic [31:0] b);
    logic [31:0] exp_out;
    logic [63:0] r;
    mdu_op = op;
    start  = st;
    src_a  = a;
    src_b  = b;
    #1;
    exp_out = (op == MduMfhi) ? m_hi : (op == MduMflo) ? m_lo : 32'd0;
    chk("mdu_out", mdu_out, exp_out);
    @(posedge clk);
    if (reset) begin
      m_hi    = '0;
      m_lo    = '0;
      ref_cnt = 0;
      sb.delete();
    end else if (ref_cnt > 0) begin
      ref_cnt--;
      if (ref_cnt == 0) begin
        m_hi = pend_h;
        m_lo = pend_l;
      end
    end else if (st) begin
      case (op)
        MduMult, MduMultu, MduDiv, MduDivu: begin
          r       = calc(op, a, b, m_hi, m_lo);
          pend_h  = r[63:32];
          pend_l  = r[31:0];
          ref_cnt = (op == MduMult || op == MduMultu) ? MultN : DivN;
          sb.push_back('{h: pend_h, l: pend_l, n: ref_cnt});
        end
        MduMthi: m_hi = a;
        MduMtlo: m_lo = a;
        default: ;
      endcase
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, ref_cnt > 0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(MduNone, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (ref_cnt == 0) break;
      step(MduNone, 1'b0, 32'd0, 32'd0);
    end
  endtask

  // Monitor: on every busy falling edge, pop and compare the committed result
  // and the length of the busy window.
  initial begin : monitor
    logic prev_busy;
    int   run_len;
    exp_t e;
    prev_busy = 1'b0;
    run_len   = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        prev_busy = 1'b0;
        run_len   = 0;
      end else begin
        if (busy === 1'b1) run_len++;
        if (busy === 1'b0 && prev_busy) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: busy fell with no pending result, got 1, expected 0");
          end else begin
            e = sb.pop_front();
            chk("sb_hi", hi, e.h);
            chk("sb_lo", lo, e.l);
            chk("sb_busy_len", 32'(run_len), 32'(e.n));
          end
          run_len = 0;
        end
        if (run_len == 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL busy_stuck: busy high %0d cycles, expected at most %0d", run_len, DivN);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : stim
    logic [31:0] sp[8];
    logic [31:0] a, b;
    mdu_op_e     op;
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE,
           32'h0001_0000};
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = MduNone;
    src_a  = '0;
    src_b  = '0;
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 1: signed multiply
    step(MduMult, 1'b1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("t1_hi", hi, 32'hFFFF_FFFF);
    chk("t1_lo", lo, 32'hFFFF_FFFA);
    step(MduMfhi, 1'b1, 32'd0, 32'd0);

    // 2: unsigned multiply
    step(MduMultu, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("t2_hi", hi, 32'hFFFF_FFFE);
    chk("t2_lo", lo, 32'h0000_0001);

    // 3: signed and unsigned divide
    step(MduDiv, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    chk("t3_hi", hi, 32'hFFFF_FFFF);
    step(MduDivu, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("t3u_lo", lo, 32'h7FFF_FFFC);
    chk("t3u_hi", hi, 32'h0000_0001);

    // 4: divide by zero leaves HI/LO alone
    step(MduMthi, 1'b1, 32'h11, 32'd0);
    step(MduMtlo, 1'b1, 32'h22, 32'd0);
    step(MduDiv, 1'b1, 32'h1234, 32'd0);
    wait_idle();
    chk("t4_hi", hi, 32'h11);
    chk("t4_lo", lo, 32'h22);

    // Signed overflow case
    step(MduDiv, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // 5: MTLO while busy is ignored
    step(MduMult, 1'b1, 32'd1000, 32'd3);
    step(MduNone, 1'b0, 32'd0, 32'd0);
    step(MduMtlo, 1'b1, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    chk("t5_lo", lo, 32'd3000);

    // 6: reset mid-divide, then a fresh multiply
    step(MduDiv, 1'b1, 32'd100, 32'd7);
    idle(3);
    reset = 1'b1;
    step(MduNone, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);
    step(MduMult, 1'b1, 32'd6, 32'd7);
    wait_idle();
    chk("t6_lo42", lo, 32'd42);

    // Randomized mix, including starts during busy and idle/NONE cycles
    for (int i = 0; i < 400; i++) begin
      op = mdu_op_e'($urandom_range(0, 8));
      a  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : $urandom;
      step(op, $urandom_range(0, 3) != 0, a, b);
    end
    wait_idle();
    idle(2);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
